// File: rtl/tmds_pkg.sv
// Shared types, control-period tokens and helpers for the TMDS channel encoder.
package tmds_pkg;

  typedef logic [9:0] tmds_sym_t;
  typedef logic [8:0] qm_t;

  localparam tmds_sym_t CTRL_TOKEN_00 = 10'b1101010100;
  localparam tmds_sym_t CTRL_TOKEN_01 = 10'b0010101011;
  localparam tmds_sym_t CTRL_TOKEN_10 = 10'b0101010100;
  localparam tmds_sym_t CTRL_TOKEN_11 = 10'b1010101011;

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] sum;
    sum = 4'd0;
    for (int i = 0; i < 8; i++) begin
      sum = sum + {3'b000, v[i]};
    end
    return sum;
  endfunction

endpackage

// File: rtl/TM_Choice.sv
// Transition-minimisation stage: maps a pixel byte to the 9-bit q_m word.
module TM_Choice
  import tmds_pkg::*;
(
  input  logic [7:0] i_data,
  output qm_t        o_qm
);

  logic [3:0] n1;
  logic       use_xnor;
  logic [7:0] q;

  always_comb begin
    n1       = ones8(i_data);
    // Ties (four ones) break on bit 0 so the choice is deterministic.
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !i_data[0]);
    q        = '0;
    q[0]     = i_data[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ i_data[i]) : (q[i-1] ^ i_data[i]);
    end
    o_qm = {~use_xnor, q};
  end

endmodule

// File: rtl/tmds_encoder.sv
// Registered TMDS channel encoder: transition minimisation, DC balancing and
// control-period tokens, two-cycle latency.
module tmds_encoder
  import tmds_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic [1:0] i_ctrl,
  input  logic       i_de,
  output logic [9:0] o_tmds
);

  localparam logic signed [CNT_W-1:0] ZERO = '0;
  localparam logic signed [CNT_W-1:0] TWO  = CNT_W'(2);

  qm_t        qm_comb;
  qm_t        qm_r;
  logic       de_r;
  logic [1:0] ctrl_r;

  logic signed [CNT_W-1:0] cnt;
  logic signed [CNT_W-1:0] cnt_next;
  logic signed [CNT_W-1:0] n1;
  logic signed [CNT_W-1:0] n0;
  logic signed [CNT_W-1:0] bal;
  logic signed [CNT_W-1:0] two_q8;
  logic signed [CNT_W-1:0] two_nq8;
  logic [3:0]              ones;
  tmds_sym_t               sym_next;

  TM_Choice u_tm_choice (
    .i_data (i_data),
    .o_qm   (qm_comb)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      qm_r   <= '0;
      de_r   <= 1'b0;
      ctrl_r <= 2'b00;
    end else begin
      qm_r   <= qm_comb;
      de_r   <= i_de;
      ctrl_r <= i_ctrl;
    end
  end

  always_comb begin
    ones     = ones8(qm_r[7:0]);
    n1       = $signed(CNT_W'(ones));
    n0       = $signed(CNT_W'(4'd8 - ones));
    bal      = n1 - n0;
    two_q8   = qm_r[8] ? TWO : ZERO;
    two_nq8  = qm_r[8] ? ZERO : TWO;
    sym_next = CTRL_TOKEN_00;
    cnt_next = ZERO;
    if (!de_r) begin
      // Blanking always restarts disparity so each active run begins balanced.
      cnt_next = ZERO;
      unique case (ctrl_r)
        2'b00:   sym_next = CTRL_TOKEN_00;
        2'b01:   sym_next = CTRL_TOKEN_01;
        2'b10:   sym_next = CTRL_TOKEN_10;
        default: sym_next = CTRL_TOKEN_11;
      endcase
    end else if ((cnt == ZERO) || (bal == ZERO)) begin
      sym_next = {~qm_r[8], qm_r[8], qm_r[8] ? qm_r[7:0] : ~qm_r[7:0]};
      cnt_next = qm_r[8] ? (cnt + bal) : (cnt - bal);
    end else if (((cnt > ZERO) && (bal > ZERO)) || ((cnt < ZERO) && (bal < ZERO))) begin
      sym_next = {1'b1, qm_r[8], ~qm_r[7:0]};
      cnt_next = cnt + two_q8 - bal;
    end else begin
      sym_next = {1'b0, qm_r[8], qm_r[7:0]};
      cnt_next = cnt + bal - two_nq8;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt    <= ZERO;
      o_tmds <= CTRL_TOKEN_00;
    end else begin
      cnt    <= cnt_next;
      o_tmds <= sym_next;
    end
  end

endmodule

// File: tb/tb_tmds_encoder.sv
// Self-checking bench for tmds_encoder: directed vector table, reset corners and
// a randomised run against an independent encode/decode reference.
module tb_tmds_encoder;

  logic       clk;
  logic       rst_n;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic       de;
  logic [9:0] tmds;

  int n_checks = 0;
  int n_fail   = 0;
  int model_cnt = 0;

  typedef struct {
    logic [9:0] sym;
    int         cnt;
    logic       de;
    logic [7:0] data;
  } sb_t;

  typedef struct {
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       de;
    logic [9:0] sym;
    int         cnt;
  } vec_t;

  sb_t  sb[$];
  vec_t vecs[16];

  tmds_encoder #(.CNT_W(5)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_data  (data),
    .i_ctrl  (ctrl),
    .i_de    (de),
    .o_tmds  (tmds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] d;
    logic [7:0] r;
    d = s[9] ? ~s[7:0] : s[7:0];
    r = '0;
    r[0] = d[0];
    for (int i = 1; i < 8; i++) r[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return r;
  endfunction

  // Reference: picks the symbol by the textbook rule, then tracks disparity as the
  // running sum of (ones - zeros) of the emitted symbols.
  task automatic model_step(input logic [7:0] d, input logic e, input logic [1:0] c,
                            output logic [9:0] sym, output int cnt_after);
    int   n1d, m1, b;
    logic xn, inv;
    logic [8:0] q;
    if (!e) begin
      model_cnt = 0;
      case (c)
        2'b00:   sym = 10'b1101010100;
        2'b01:   sym = 10'b0010101011;
        2'b10:   sym = 10'b0101010100;
        default: sym = 10'b1010101011;
      endcase
    end else begin
      n1d = $countones(d);
      xn  = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
      q[0] = d[0];
      for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
      q[8] = ~xn;
      m1 = $countones(q[7:0]);
      b  = 2 * m1 - 8;
      if (model_cnt == 0 || b == 0) inv = ~q[8];
      else if ((model_cnt > 0 && b > 0) || (model_cnt < 0 && b < 0)) inv = 1'b1;
      else inv = 1'b0;
      sym = {inv, q[8], inv ? ~q[7:0] : q[7:0]};
      model_cnt = model_cnt + 2 * $countones(sym) - 10;
    end
    cnt_after = model_cnt;
  endtask

  task automatic check_out();
    sb_t e;
    int  dcnt;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    dcnt = int'(dut.cnt);
    check("symbol", tmds, e.sym);
    check("cnt", dcnt, e.cnt);
    check("cnt_bound", (dcnt <= 10 && dcnt >= -10), 1);
    if (e.de) check("decode", decode(tmds), e.data);
  endtask

  task automatic step(input logic [7:0] d, input logic [1:0] c, input logic e, input sb_t exp);
    data = d; ctrl = c; de = e;
    sb.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    check_out();
  endtask

  task automatic rand_step(input logic force_de, input logic [7:0] d_in);
    logic [7:0] d;
    logic [1:0] c;
    logic       e;
    logic [9:0] s;
    int         ca;
    sb_t        x;
    d = force_de ? d_in : 8'($urandom);
    c = 2'($urandom_range(0, 3));
    e = force_de ? 1'b1 : ($urandom_range(0, 7) != 0);
    model_step(d, e, c, s, ca);
    x = '{sym: s, cnt: ca, de: e, data: d};
    step(d, c, e, x);
  endtask

  task automatic restart_scoreboard();
    sb.delete();
    model_cnt = 0;
    sb.push_back('{sym: 10'b1101010100, cnt: 0, de: 1'b0, data: 8'h00});
  endtask

  initial begin
    logic [9:0] s;
    int         ca;
    sb_t        x;

    vecs[0]  = '{8'h00, 2'b00, 1'b0, 10'b1101010100,  0};
    vecs[1]  = '{8'h00, 2'b01, 1'b0, 10'b0010101011,  0};
    vecs[2]  = '{8'h00, 2'b10, 1'b0, 10'b0101010100,  0};
    vecs[3]  = '{8'h00, 2'b11, 1'b0, 10'b1010101011,  0};
    vecs[4]  = '{8'h00, 2'b00, 1'b1, 10'b0100000000, -8};
    vecs[5]  = '{8'h00, 2'b00, 1'b1, 10'b1111111111,  2};
    vecs[6]  = '{8'h00, 2'b00, 1'b0, 10'b1101010100,  0};
    vecs[7]  = '{8'h00, 2'b00, 1'b1, 10'b0100000000, -8};
    vecs[8]  = '{8'h00, 2'b00, 1'b0, 10'b1101010100,  0};
    vecs[9]  = '{8'hFF, 2'b00, 1'b1, 10'b1000000000, -8};
    vecs[10] = '{8'hFF, 2'b00, 1'b1, 10'b0011111111, -2};
    vecs[11] = '{8'h00, 2'b00, 1'b0, 10'b1101010100,  0};
    vecs[12] = '{8'h55, 2'b00, 1'b1, 10'b0100110011,  0};
    vecs[13] = '{8'h00, 2'b00, 1'b1, 10'b0100000000, -8};
    vecs[14] = '{8'h55, 2'b00, 1'b1, 10'b0100110011, -8};
    vecs[15] = '{8'h00, 2'b11, 1'b0, 10'b1010101011,  0};

    rst_n = 1'b0; data = '0; ctrl = '0; de = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      data = 8'($urandom); ctrl = 2'($urandom_range(0, 3)); de = 1'($urandom_range(0, 1));
      check("reset_out", tmds, 10'b1101010100);
      check("reset_cnt", int'(dut.cnt), 0);
    end

    @(negedge clk);
    rst_n = 1'b1;
    restart_scoreboard();
    foreach (vecs[i]) begin
      model_step(vecs[i].data, vecs[i].de, vecs[i].ctrl, s, ca);
      x = '{sym: vecs[i].sym, cnt: vecs[i].cnt, de: vecs[i].de, data: vecs[i].data};
      step(vecs[i].data, vecs[i].ctrl, vecs[i].de, x);
    end

    for (int i = 0; i < 20000; i++) rand_step(1'b0, 8'h00);

    for (int i = 0; i < 5; i++) rand_step(1'b1, 8'($urandom));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midline_reset_out", tmds, 10'b1101010100);
    check("midline_reset_cnt", int'(dut.cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    restart_scoreboard();
    rand_step(1'b1, 8'h00);
    rand_step(1'b1, 8'h00);
    check("post_reset_first_pixel", tmds, 10'b0100000000);
    rand_step(1'b1, 8'h00);
    check("post_reset_second_pixel", tmds, 10'b1111111111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
